// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with a per-register busy
// scoreboard for multi-cycle producers (loads, divider).
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high; clears all registers and busy bits
//   we/wa/wd  writeback port: regs[wa] <= wd at the edge
//   wclr      with we, clears busy[wa]
//   iss/ia    issue: marks busy[ia] at the next edge
//   flush     clears every busy bit at the next edge (beats issue)
//   ra        packed read addresses, port i at [i*AW +: AW]
//   rd        packed read data, port i at [i*XLEN +: XLEN], combinational
//   rbusy     per-port busy flag for the addressed register
//   any_busy  OR of the busy bits as they stand after the last edge
module regfile_sb #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [AW-1:0]         wa,
   input  logic [XLEN-1:0]       wd,
   input  logic                  wclr,
   input  logic                  iss,
   input  logic [AW-1:0]         ia,
   input  logic                  flush,
   input  logic [NREAD*AW-1:0]   ra,
   output logic [NREAD*XLEN-1:0] rd,
   output logic [NREAD-1:0]      rbusy,
   output logic                  any_busy
);

   // Flops rather than a RAM: the contents need an asynchronous clear.
   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;
   logic             wr_ok;

   assign wr_ok = we && !((ZERO_REG != 0) && (wa == '0));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int n = 0; n < NREGS; n++) begin
            regs[n] <= '0;
         end
         busy <= '0;
      end else begin
         if (wr_ok) begin
            regs[wa] <= wd;
         end
         busy <= busy_nxt;
      end
   end

   // Later assignments win: clear < issue < flush. Issue beats a same-cycle
   // clear of the same register because the new producer owns it.
   always_comb begin
      busy_nxt = busy;
      if (we && wclr) begin
         busy_nxt[wa] = 1'b0;
      end
      if (iss) begin
         busy_nxt[ia] = 1'b1;
      end
      if (flush) begin
         busy_nxt = '0;
      end
      if (ZERO_REG != 0) begin
         busy_nxt[0] = 1'b0;
      end
   end

   // Registered view only; a same-cycle issue shows up after the edge.
   assign any_busy = |busy;

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [AW-1:0] a;
      logic          hit;
      logic          zero;

      assign a    = ra[i*AW +: AW];
      assign hit  = (BYPASS != 0) && we && (wa == a);
      assign zero = (ZERO_REG != 0) && (a == '0);

      assign rd[i*XLEN +: XLEN] = zero ? '0 : (hit ? wd : regs[a]);
      // A value being written back this cycle is forwarded, so the reader
      // need not stall on it.
      assign rbusy[i] = busy[a] & ~(hit & wclr);
   end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        reset;
   logic        we, wclr, iss, flush;
   logic [4:0]  wa, ia, ra0, ra1, ra2;
   logic [63:0] wd;

   logic [63:0]  rd_a, rd_b;
   logic [191:0] rd_c;
   logic [1:0]   rb_a, rb_b;
   logic [2:0]   rb_c;
   logic         any_a, any_b, any_c;

   always #5 clk = ~clk;

   // default configuration
   regfile_sb u_a (
      .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd[31:0]), .wclr(wclr),
      .iss(iss), .ia(ia), .flush(flush), .ra({ra1, ra0}),
      .rd(rd_a), .rbusy(rb_a), .any_busy(any_a)
   );

   // no bypass
   regfile_sb #(.BYPASS(0)) u_b (
      .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd[31:0]), .wclr(wclr),
      .iss(iss), .ia(ia), .flush(flush), .ra({ra1, ra0}),
      .rd(rd_b), .rbusy(rb_b), .any_busy(any_b)
   );

   // wide data, 16 registers, three read ports
   regfile_sb #(.XLEN(64), .NREGS(16), .NREAD(3)) u_c (
      .clk(clk), .reset(reset), .we(we), .wa(wa[3:0]), .wd(wd), .wclr(wclr),
      .iss(iss), .ia(ia[3:0]), .flush(flush),
      .ra({ra2[3:0], ra1[3:0], ra0[3:0]}),
      .rd(rd_c), .rbusy(rb_c), .any_busy(any_c)
   );

   typedef struct {
      string       name;
      int          inst;
      int          port;
      logic [63:0] rd;
      logic        rbusy;
      logic        any;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   event chk_now;

   // 64-bit data used for the wide instance: low half is the 32-bit value
   function automatic logic [63:0] ext(input logic [31:0] lo);
      return (lo == 32'd0) ? 64'd0 : {~lo, lo};
   endfunction

   // Push one expectation per instance; the wide instance (bypass on)
   // follows the default instance's expectation.
   task automatic exp3(input string n, input int p, input logic [31:0] d0,
                       input logic [31:0] d1, input logic b0, input logic b1,
                       input logic any);
      exp_t e;
      if (p < 2) begin
         e = '{n, 0, p, {32'd0, d0}, b0, any}; q.push_back(e);
         e = '{n, 1, p, {32'd0, d1}, b1, any}; q.push_back(e);
      end
      e = '{n, 2, p, ext(d0), b0, any}; q.push_back(e);
   endtask

   // monitor: pops and compares whenever outputs are sampled
   initial begin
      exp_t        e;
      logic [63:0] ard;
      logic        ab, aa;
      forever begin
         @(negedge clk or chk_now);
         while (q.size() > 0) begin
            e = q.pop_front();
            case (e.inst)
               0:       begin ard = {32'd0, rd_a[e.port*32 +: 32]}; ab = rb_a[e.port]; aa = any_a; end
               1:       begin ard = {32'd0, rd_b[e.port*32 +: 32]}; ab = rb_b[e.port]; aa = any_b; end
               default: begin ard = rd_c[e.port*64 +: 64];          ab = rb_c[e.port]; aa = any_c; end
            endcase
            checks++;
            if (ard !== e.rd || ab !== e.rbusy || aa !== e.any) begin
               errors++;
               $display("FAIL %s inst%0d port%0d: got rd=%h rbusy=%b any=%b, want rd=%h rbusy=%b any=%b",
                        e.name, e.inst, e.port, ard, ab, aa, e.rd, e.rbusy, e.any);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      we = 1'b0; wclr = 1'b0; iss = 1'b0; flush = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      we = 0; wclr = 0; iss = 0; flush = 0;
      wa = 0; ia = 0; ra0 = 0; ra1 = 0; ra2 = 0; wd = 0;
      tick();
      tick(); ra0 = 5;
      exp3("reset_state", 0, 0, 0, 0, 0, 0);
      tick(); reset = 1'b0;

      // async reset mid-cycle
      we = 1; wa = 5; wd = ext(32'hDEADBEEF);
      tick();
      exp3("wr_x5", 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
      @(negedge clk); #1;
      reset = 1'b1;
      we = 1; wa = 6; wd = ext(32'h66666666); iss = 1; ia = 5;
      #1;
      exp3("async_reset", 0, 0, 0, 0, 0, 0);
      -> chk_now;
      tick();
      tick(); reset = 1'b0; ra0 = 5; ra1 = 6;
      exp3("post_reset_x5", 0, 0, 0, 0, 0, 0);
      exp3("post_reset_x6", 1, 0, 0, 0, 0, 0);

      // write / read, all ports on one register
      tick(); we = 1; wa = 7; wd = ext(32'h12345678);
      tick(); ra0 = 7; ra1 = 7; ra2 = 7;
      exp3("rd_p0", 0, 32'h12345678, 32'h12345678, 0, 0, 0);
      exp3("rd_p1", 1, 32'h12345678, 32'h12345678, 0, 0, 0);
      exp3("rd_p2", 2, 32'h12345678, 32'h12345678, 0, 0, 0);

      // x0 ignores writes, also not forwarded
      tick(); we = 1; wa = 0; wd = ext(32'hFFFFFFFF); ra0 = 0;
      exp3("x0_wr_cycle", 0, 0, 0, 0, 0, 0);
      tick();
      exp3("x0_read", 0, 0, 0, 0, 0, 0);

      // bypass
      tick(); we = 1; wa = 3; wd = ext(32'h11111111);
      tick(); we = 1; wa = 3; wd = ext(32'hA5A5A5A5); ra0 = 3;
      exp3("bypass", 0, 32'hA5A5A5A5, 32'h11111111, 0, 0, 0);
      tick();
      exp3("bypass_after", 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0);

      // scoreboard issue / clear
      tick(); iss = 1; ia = 9; ra0 = 9;
      exp3("iss_same_cycle", 0, 0, 0, 0, 0, 0);
      tick();
      exp3("iss_next", 0, 0, 0, 1, 1, 1);
      tick(); wclr = 1; wa = 9;
      exp3("wclr_no_we", 0, 0, 0, 1, 1, 1);
      tick();
      exp3("wclr_no_we_next", 0, 0, 0, 1, 1, 1);
      tick(); we = 1; wclr = 1; wa = 9; wd = ext(32'h00000099);
      exp3("clr_bypass", 0, 32'h99, 0, 0, 1, 1);
      tick();
      exp3("clr_next", 0, 32'h99, 32'h99, 0, 0, 0);

      // issue and clear of the same register in one cycle
      tick(); iss = 1; ia = 4; we = 1; wclr = 1; wa = 4; wd = ext(32'h44444444); ra0 = 4;
      exp3("collide_cycle", 0, 32'h44444444, 0, 0, 0, 0);
      tick();
      exp3("collide_next", 0, 32'h44444444, 32'h44444444, 1, 1, 1);
      tick(); we = 1; wclr = 1; wa = 4; wd = ext(32'h44444444);
      tick(); iss = 1; ia = 0; ra0 = 0;
      exp3("iss_x0", 0, 0, 0, 0, 0, 0);
      tick();
      exp3("iss_x0_next", 0, 0, 0, 0, 0, 0);

      // flush beats a same-cycle issue
      tick(); iss = 1; ia = 1;
      tick(); iss = 1; ia = 2;
      tick(); iss = 1; ia = 31;
      tick(); ra0 = 1; ra1 = 2; ra2 = 31;
      exp3("busy_p0", 0, 0, 0, 1, 1, 1);
      exp3("busy_p1", 1, 0, 0, 1, 1, 1);
      exp3("busy_p2", 2, 0, 0, 1, 1, 1);
      tick(); flush = 1; iss = 1; ia = 6;
      exp3("flush_cycle", 0, 0, 0, 1, 1, 1);
      tick(); ra0 = 6;
      exp3("flush_p0", 0, 0, 0, 0, 0, 0);
      exp3("flush_p1", 1, 0, 0, 0, 0, 0);
      exp3("flush_p2", 2, 0, 0, 0, 0, 0);

      tick();
      tick();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
